// File: rtl/clk_div_gen.sv
// Programmable clock divider with a toggle or pulse output, a tick strobe,
// a modulo tick counter and a handshaked divisor load.
module clk_div_gen #(
  parameter int CNT_W    = 26,
  parameter int DEF_DIV  = 10000000,
  parameter int TICK_MOD = 60,
  parameter int TICK_W   = 6
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              en,
  input  logic              mode,
  input  logic [CNT_W-1:0]  div_in,
  input  logic              div_load,
  output logic              div_ack,
  output logic              clk_out,
  output logic              tick,
  output logic [TICK_W-1:0] tick_cnt,
  output logic              wrap
);

  localparam logic [CNT_W-1:0]  DIV_RST  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [TICK_W-1:0] TICK_ONE = TICK_W'(1);
  localparam logic [TICK_W-1:0] TICK_TOP = TICK_W'(TICK_MOD - 1);

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] div_reg;
  logic             tc;
  logic             tick_last;

  assign tc        = en && (counter == (div_reg - CNT_ONE));
  assign tick_last = (tick_cnt == TICK_TOP);

  // A load outranks a coincident terminal count; in pulse mode clk_out
  // simply mirrors the tick strobe, so every non-tick update drives it low.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      counter  <= '0;
      div_reg  <= DIV_RST;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      div_ack  <= 1'b0;
      tick_cnt <= '0;
    end else begin
      div_ack <= div_load;
      tick    <= 1'b0;
      wrap    <= 1'b0;
      if (div_load) begin
        div_reg <= (div_in == '0) ? CNT_ONE : div_in;
        counter <= '0;
        if (mode) clk_out <= 1'b0;
      end else if (tc) begin
        counter  <= '0;
        tick     <= 1'b1;
        clk_out  <= mode ? 1'b1 : ~clk_out;
        tick_cnt <= tick_last ? '0 : tick_cnt + TICK_ONE;
        wrap     <= tick_last;
      end else begin
        if (en) counter <= counter + CNT_ONE;
        if (mode) clk_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Randomized self-checking bench for clk_div_gen against a period/tick-count
// model, with literal anchors for reset, first tick, loads and async reset.
module tb_clk_div_gen;

  localparam int CNT_W    = 4;
  localparam int DEF_DIV  = 3;
  localparam int TICK_MOD = 4;
  localparam int TICK_W   = 2;

  logic              clk_in = 1'b0;
  logic              rst_n;
  logic              en;
  logic              mode;
  logic [CNT_W-1:0]  div_in;
  logic              div_load;
  logic              div_ack;
  logic              clk_out;
  logic              tick;
  logic [TICK_W-1:0] tick_cnt;
  logic              wrap;

  int vectors = 0;
  int miscompares = 0;

  // Model: cycles elapsed in the current period, active divisor, total ticks.
  int   m_phase, m_div, m_ticks;
  logic m_clk, m_tick, m_wrap, m_ack;

  clk_div_gen #(
    .CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .TICK_MOD(TICK_MOD), .TICK_W(TICK_W)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .mode(mode),
    .div_in(div_in), .div_load(div_load), .div_ack(div_ack),
    .clk_out(clk_out), .tick(tick), .tick_cnt(tick_cnt), .wrap(wrap)
  );

  always #5 clk_in = ~clk_in;

  task automatic cmp(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    m_phase = 0; m_div = DEF_DIV; m_ticks = 0;
    m_clk = 1'b0; m_tick = 1'b0; m_wrap = 1'b0; m_ack = 1'b0;
  endtask

  // One clock's worth of behaviour, computed from the inputs about to be sampled.
  task automatic modelStep();
    m_ack  = div_load;
    m_tick = 1'b0;
    m_wrap = 1'b0;
    if (div_load) begin
      m_div   = (div_in == 0) ? 1 : int'(div_in);
      m_phase = 0;
      if (mode) m_clk = 1'b0;
    end else if (en) begin
      m_phase++;
      if (m_phase == m_div) begin
        m_phase = 0;
        m_ticks++;
        m_tick = 1'b1;
        m_wrap = (m_ticks % TICK_MOD) == 0;
        m_clk  = mode ? 1'b1 : ~m_clk;
      end else if (mode) m_clk = 1'b0;
    end else if (mode) m_clk = 1'b0;
  endtask

  task automatic checkOutput();
    vectors++;
    cmp("div_ack",  int'(div_ack),  int'(m_ack));
    cmp("clk_out",  int'(clk_out),  int'(m_clk));
    cmp("tick",     int'(tick),     int'(m_tick));
    cmp("wrap",     int'(wrap),     int'(m_wrap));
    cmp("tick_cnt", int'(tick_cnt), m_ticks % TICK_MOD);
  endtask

  task automatic applyStimulus(input logic e, input logic md, input logic ld, input logic [CNT_W-1:0] d);
    en = e; mode = md; div_load = ld; div_in = d;
    modelStep();
    @(posedge clk_in);
    @(negedge clk_in);
    checkOutput();
  endtask

  // Pulses rst_n low between edges and checks that outputs clear at once.
  task automatic asyncReset();
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    cmp("rst_clk_out",  int'(clk_out),  0);
    cmp("rst_tick",     int'(tick),     0);
    cmp("rst_wrap",     int'(wrap),     0);
    cmp("rst_div_ack",  int'(div_ack),  0);
    cmp("rst_tick_cnt", int'(tick_cnt), 0);
    modelReset();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic e, md, ld;
    logic [CNT_W-1:0] d;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; div_load = 1'b0; div_in = '0;
    modelReset();
    #12;
    checkOutput();
    @(negedge clk_in);
    rst_n = 1'b1;

    // First tick at the 3rd enabled edge; clk_out toggles on each tick.
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      cmp("lit_tick",     int'(tick),     (i % 3 == 0) ? 1 : 0);
      cmp("lit_clk_out",  int'(clk_out),  (i / 3) % 2);
      cmp("lit_tick_cnt", int'(tick_cnt), (i / 3) % 4);
      cmp("lit_wrap",     int'(wrap),     (i == 12) ? 1 : 0);
    end

    // Load 5 mid-period: ack next cycle, next tick 5 cycles after the load.
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd5);
    cmp("lit_ack", int'(div_ack), 1);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      cmp("lit_load5_tick", int'(tick), (i == 5) ? 1 : 0);
    end

    // Divisor 0 behaves as 1: tick every cycle.
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      cmp("lit_div1_tick", int'(tick), 1);
    end

    // Pulse mode and a freeze window.
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd3);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      cmp("lit_frozen_tick", int'(tick), 0);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0);

    // Reach clk_out=1 with tick_cnt=2, then reset between edges.
    asyncReset();
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    cmp("lit_pre_rst_clk", int'(clk_out), 1);
    cmp("lit_pre_rst_cnt", int'(tick_cnt), 2);
    asyncReset();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0);
      cmp("lit_post_rst_tick", int'(tick), (i == 3) ? 1 : 0);
    end

    // Randomized traffic.
    md = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      e  = ($urandom_range(7, 0) != 0);
      if ($urandom_range(31, 0) == 0) md = ~md;
      ld = ($urandom_range(15, 0) == 0);
      d  = ($urandom_range(7, 0) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(6, 0));
      applyStimulus(e, md, ld, d);
      if ($urandom_range(199, 0) == 0) asyncReset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
